// File: rtl/bank_timing_tracker_if.sv
// -----------------------------------------------------------------------------
// bank_timing_tracker_if
// Decoded-command bus feeding one rank's bank timing tracker.
//   cmd_valid : command present this cycle
//   cmd       : 0 NOP, 1 ACT, 2 RD, 3 WR, 4 PRE, 5 PREA, 6 REF, 7 reserved
//   cmd_bg    : target bank group (ignored for PREA/REF)
//   cmd_ba    : target bank within the group (ignored for PREA/REF)
//   cmd_ap    : auto-precharge qualifier for RD/WR
// master = command decoder side, slave = tracker side.
// -----------------------------------------------------------------------------
interface bank_timing_tracker_if #(
    parameter int BGWIDTH = 2,
    parameter int BAWIDTH = 2
);
    logic               cmd_valid;
    logic [2:0]         cmd;
    logic [BGWIDTH-1:0] cmd_bg;
    logic [BAWIDTH-1:0] cmd_ba;
    logic               cmd_ap;

    modport master (output cmd_valid, cmd, cmd_bg, cmd_ba, cmd_ap);
    modport slave  (input  cmd_valid, cmd, cmd_bg, cmd_ba, cmd_ap);
endinterface

// File: rtl/bank_timing_tracker.sv
// -----------------------------------------------------------------------------
// bank_timing_tracker
// Per-bank DDR4 timing state tracker for one rank of the DIMM emulator.
// Judges each decoded command against the bank state held before the clock
// edge, advances every bank's state/down-timer, and reports rejected commands.
// Ports:
//   ck_tp      : memory clock, rising edge active
//   reset_n    : asynchronous active-low reset
//   cmd_if     : decoded command bus (slave modport)
//   bank_state : 5-bit state code of bank k at [5k+4:5k], k = bg*2**BAWIDTH+ba
//   bank_open  : bit k set while bank k is ACTIVATING/ACTIVE/READING/WRITING
//   err        : one-cycle pulse, previous-cycle command was rejected
//   err_code   : 1 busy, 2 not active, 3 not idle, 4 tRAS unmet, 5 reserved cmd
//   err_count  : saturating count of rejected commands
// -----------------------------------------------------------------------------
module bank_timing_tracker #(
    parameter int BGWIDTH = 2,
    parameter int BAWIDTH = 2,
    parameter int BL      = 8,
    parameter int T_RCD   = 17,
    parameter int T_CL    = 17,
    parameter int T_CWL   = 10,
    parameter int T_RP    = 17,
    parameter int T_WR    = 14,
    parameter int T_RAS   = 32,
    parameter int T_RFC   = 34
) (
    input  logic                                   ck_tp,
    input  logic                                   reset_n,
    bank_timing_tracker_if.slave                   cmd_if,
    output logic [5*(1<<(BGWIDTH+BAWIDTH))-1:0]    bank_state,
    output logic [(1<<(BGWIDTH+BAWIDTH))-1:0]      bank_open,
    output logic                                   err,
    output logic [2:0]                             err_code,
    output logic [7:0]                             err_count
);
    localparam int NB = 1 << (BGWIDTH + BAWIDTH);

    // Timer reload values are D-1 so a state lasts exactly D cycles.
    localparam logic [15:0] LD_RCD  = 16'(T_RCD - 1);
    localparam logic [15:0] LD_RD   = 16'(T_CL + BL/2 - 1);
    localparam logic [15:0] LD_WR   = 16'(T_CWL + BL/2 + T_WR - 1);
    localparam logic [15:0] LD_RP   = 16'(T_RP - 1);
    localparam logic [15:0] LD_RFC  = 16'(T_RFC - 1);
    localparam logic [15:0] RAS_MIN = 16'(T_RAS);

    typedef enum logic [4:0] {
        ST_IDLE        = 5'h00,
        ST_ACTIVATING  = 5'h01,
        ST_ACTIVE      = 5'h03,
        ST_REFRESHING  = 5'h05,
        ST_PRECHARGING = 5'h0a,
        ST_READING     = 5'h0b,
        ST_WRITING     = 5'h12
    } bank_st_t;

    typedef enum logic [2:0] {
        CMD_NOP, CMD_ACT, CMD_RD, CMD_WR, CMD_PRE, CMD_PREA, CMD_REF, CMD_RSVD
    } cmd_t;

    bank_st_t    state_q [NB];
    bank_st_t    state_d [NB];
    logic [15:0] timer_q [NB];
    logic [15:0] timer_d [NB];
    logic [15:0] ras_q   [NB];
    logic [15:0] ras_d   [NB];
    logic        ap_q    [NB];
    logic        ap_d    [NB];

    logic                       rej;
    logic [2:0]                 rej_code;
    cmd_t                       cmd;
    logic [BGWIDTH+BAWIDTH-1:0] tgt;

    function automatic logic is_busy(input bank_st_t s);
        return (s == ST_ACTIVATING) || (s == ST_READING) || (s == ST_WRITING);
    endfunction

    assign cmd = cmd_t'(cmd_if.cmd);
    assign tgt = {cmd_if.cmd_bg, cmd_if.cmd_ba};

    // Legality is decided purely on pre-edge state, so a timer expiring on the
    // same edge never rescues a command.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves
        // it unassigned, which would otherwise infer a latch.
        rej      = 1'b0;
        rej_code = 3'd0;
        if (cmd_if.cmd_valid) begin
            unique case (cmd)
                CMD_ACT: if (state_q[tgt] != ST_IDLE) begin
                    rej = 1'b1; rej_code = 3'd3;
                end
                CMD_RD, CMD_WR: if (state_q[tgt] != ST_ACTIVE) begin
                    rej = 1'b1; rej_code = is_busy(state_q[tgt]) ? 3'd1 : 3'd2;
                end
                CMD_PRE: begin
                    if (is_busy(state_q[tgt])) begin
                        rej = 1'b1; rej_code = 3'd1;
                    end else if (state_q[tgt] == ST_ACTIVE && ras_q[tgt] < RAS_MIN) begin
                        rej = 1'b1; rej_code = 3'd4;
                    end
                end
                // All-or-nothing; the lowest offending bank decides the code.
                CMD_PREA: for (int k = 0; k < NB; k++) begin
                    if (!rej && is_busy(state_q[k])) begin
                        rej = 1'b1; rej_code = 3'd1;
                    end else if (!rej && state_q[k] == ST_ACTIVE && ras_q[k] < RAS_MIN) begin
                        rej = 1'b1; rej_code = 3'd4;
                    end
                end
                CMD_REF: for (int k = 0; k < NB; k++) begin
                    if (state_q[k] != ST_IDLE) begin
                        rej = 1'b1; rej_code = 3'd3;
                    end
                end
                CMD_RSVD: begin
                    rej = 1'b1; rej_code = 3'd5;
                end
                default: ;
            endcase
        end
    end

    // Next-state per bank. Accepted commands only ever target banks sitting in
    // untimed states, so they never collide with a timer expiry.
    always_comb begin
        for (int k = 0; k < NB; k++) begin
            state_d[k] = state_q[k];
            timer_d[k] = timer_q[k];
            ap_d[k]    = ap_q[k];
            ras_d[k]   = (ras_q[k] < RAS_MIN) ? ras_q[k] + 16'd1 : ras_q[k];

            unique case (state_q[k])
                ST_ACTIVATING: begin
                    if (timer_q[k] == '0) state_d[k] = ST_ACTIVE;
                    else                  timer_d[k] = timer_q[k] - 16'd1;
                end
                ST_READING, ST_WRITING: begin
                    if (timer_q[k] != '0) begin
                        timer_d[k] = timer_q[k] - 16'd1;
                    end else if (!ap_q[k]) begin
                        state_d[k] = ST_ACTIVE;
                    end else if (ras_q[k] >= RAS_MIN) begin
                        // Auto-precharge parks at timer 0 until tRAS is met.
                        state_d[k] = ST_PRECHARGING;
                        timer_d[k] = LD_RP;
                    end
                end
                ST_PRECHARGING, ST_REFRESHING: begin
                    if (timer_q[k] == '0) state_d[k] = ST_IDLE;
                    else                  timer_d[k] = timer_q[k] - 16'd1;
                end
                default: ;
            endcase

            if (cmd_if.cmd_valid && !rej) begin
                unique case (cmd)
                    CMD_ACT: if (k == int'(tgt)) begin
                        state_d[k] = ST_ACTIVATING;
                        timer_d[k] = LD_RCD;
                        ras_d[k]   = 16'd1;
                    end
                    CMD_RD: if (k == int'(tgt)) begin
                        state_d[k] = ST_READING;
                        timer_d[k] = LD_RD;
                        ap_d[k]    = cmd_if.cmd_ap;
                    end
                    CMD_WR: if (k == int'(tgt)) begin
                        state_d[k] = ST_WRITING;
                        timer_d[k] = LD_WR;
                        ap_d[k]    = cmd_if.cmd_ap;
                    end
                    CMD_PRE: if (k == int'(tgt) && state_q[k] == ST_ACTIVE) begin
                        state_d[k] = ST_PRECHARGING;
                        timer_d[k] = LD_RP;
                    end
                    CMD_PREA: if (state_q[k] == ST_ACTIVE) begin
                        state_d[k] = ST_PRECHARGING;
                        timer_d[k] = LD_RP;
                    end
                    CMD_REF: begin
                        state_d[k] = ST_REFRESHING;
                        timer_d[k] = LD_RFC;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge ck_tp or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: the per-bank arrays are plain flops, not a RAM macro, so they
            // take the async reset; this is what clears in-flight bursts/refresh.
            for (int k = 0; k < NB; k++) begin
                state_q[k] <= ST_IDLE;
                timer_q[k] <= '0;
                ras_q[k]   <= '0;
                ap_q[k]    <= 1'b0;
            end
            err       <= 1'b0;
            err_code  <= 3'd0;
            err_count <= 8'd0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling the
            // pre-edge values, independent of statement order.
            for (int k = 0; k < NB; k++) begin
                state_q[k] <= state_d[k];
                timer_q[k] <= timer_d[k];
                ras_q[k]   <= ras_d[k];
                ap_q[k]    <= ap_d[k];
            end
            err      <= rej;
            err_code <= rej ? rej_code : 3'd0;
            if (rej && err_count != 8'hFF) err_count <= err_count + 8'd1;
        end
    end

    always_comb begin
        for (int k = 0; k < NB; k++) begin
            bank_state[5*k +: 5] = state_q[k];
            bank_open[k] = is_busy(state_q[k]) || (state_q[k] == ST_ACTIVE);
        end
    end
endmodule
